// File: rtl/itrx_apbm_apb_fsm.sv
// APB3 master sequencer for the SPI-to-APB bridge: runs one APB transfer or a
// bus-reset pulse per request, with a bounded wait on pready.
module itrx_apbm_apb_fsm #(
  parameter int unsigned ADDR_BITS_N    = 3,
  parameter int unsigned DATA_BITS_M    = 8,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   trans_start,
  input  logic                   assert_preset,
  input  logic [ADDR_BITS_N-1:0] paddr_in,
  input  logic [DATA_BITS_M-1:0] pwdata_in,
  input  logic                   pwrite_in,
  input  logic                   pready,
  input  logic [DATA_BITS_M-1:0] prdata,
  input  logic                   pslverr,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_BITS_N-1:0] paddr,
  output logic [DATA_BITS_M-1:0] pwdata,
  output logic                   presetn,
  output logic                   trans_done,
  output logic [DATA_BITS_M-1:0] rdata,
  output logic                   err_slv,
  output logic                   err_timeout
);

  localparam int unsigned        CNT_W    = 8;
  localparam logic [CNT_W-1:0]   RST_LOAD = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]   TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_BUSRST = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q;
  logic                   req_s_q;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_BITS_N-1:0] paddr_q, paddr_d;
  logic [DATA_BITS_M-1:0] pwdata_q, pwdata_d;
  logic                   presetn_q, presetn_d;
  logic                   trans_done_q, trans_done_d;
  logic [DATA_BITS_M-1:0] rdata_q, rdata_d;
  logic                   err_slv_q, err_slv_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Next-state and next-output decode; every register holds unless a state acts on it.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    presetn_d     = 1'b1;
    trans_done_d  = trans_done_q;
    rdata_d       = rdata_q;
    err_slv_d     = err_slv_q;
    err_timeout_d = err_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        trans_done_d = 1'b1;
        if (req_s_q) begin
          paddr_d       = paddr_in;
          pwdata_d      = pwdata_in;
          pwrite_d      = pwrite_in;
          err_slv_d     = 1'b0;
          err_timeout_d = 1'b0;
          trans_done_d  = 1'b0;
          if (assert_preset) begin
            state_d   = S_BUSRST;
            presetn_d = 1'b0;
            cnt_d     = RST_LOAD;
          end else begin
            state_d = S_SETUP;
            psel_d  = 1'b1;
          end
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = TO_LOAD;
      end

      S_ACCESS: begin
        // pready is checked first so it wins over a timeout in the same cycle
        if (pready) begin
          if (!pwrite_q) begin
            rdata_d = prdata;
          end
          err_slv_d    = pslverr;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          trans_done_d = 1'b1;
          state_d      = S_DONE;
        end else if (TO_EN) begin
          if (cnt_q <= CNT_ONE) begin
            err_timeout_d = 1'b1;
            if (!pwrite_q) begin
              rdata_d = '1;
            end
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            trans_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      S_BUSRST: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cnt_q <= CNT_ONE) begin
          trans_done_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          presetn_d = 1'b0;
          cnt_d     = cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        trans_done_d = 1'b1;
        if (!req_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d      = S_IDLE;
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        trans_done_d = 1'b1;
      end
    endcase
  end

  // All state, including the request synchronizer, in one clocked block.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b0;
      req_s_q       <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      presetn_q     <= 1'b0;
      trans_done_q  <= 1'b1;
      rdata_q       <= '0;
      err_slv_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= trans_start;
      req_s_q       <= sync1_q;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      presetn_q     <= presetn_d;
      trans_done_q  <= trans_done_d;
      rdata_q       <= rdata_d;
      err_slv_q     <= err_slv_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign presetn     = presetn_q;
  assign trans_done  = trans_done_q;
  assign rdata       = rdata_q;
  assign err_slv     = err_slv_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_itrx_apbm_apb_fsm.sv
// Bench for itrx_apbm_apb_fsm: directed vector table, reset corner cases and
// random transfers checked against a cycle-count model of the sequencer.
module tb_itrx_apbm_apb_fsm;

  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned RSTC = 4;
  localparam int unsigned TOC  = 16;
  localparam int          NEVER = 255;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          trans_start = 1'b0;
  logic          assert_preset = 1'b0;
  logic [AW-1:0] paddr_in = '0;
  logic [DW-1:0] pwdata_in = '0;
  logic          pwrite_in = 1'b0;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;
  logic          psel, penable, pwrite, presetn, trans_done, err_slv, err_timeout;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, rdata;

  int n_cmp = 0;
  int n_err = 0;

  itrx_apbm_apb_fsm #(
    .ADDR_BITS_N(AW), .DATA_BITS_M(DW), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .pclk(pclk), .rst(rst), .trans_start(trans_start), .assert_preset(assert_preset),
    .paddr_in(paddr_in), .pwdata_in(pwdata_in), .pwrite_in(pwrite_in),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .presetn(presetn), .trans_done(trans_done), .rdata(rdata),
    .err_slv(err_slv), .err_timeout(err_timeout)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic          preset;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdv;
    int            waits;   // pready=0 cycles in ACCESS before pready=1
    logic          slverr;
  } vec_t;

  typedef struct {
    bit            finished;
    int            done;    // edges from trans_start rise to trans_done rise
    int            psel_c;
    int            pen_c;
    int            rst_c;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [DW-1:0] rdata;
    logic          es;
    logic          et;
    bit            retrig;
  } obs_t;

  typedef struct {
    vec_t          v;
    int            done;
    logic [DW-1:0] rdata;
    logic          es;
    logic          et;
  } row_t;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Behaviour from the transfer rules: latency 2 sync + 1 decode, then
  // SETUP(1) + ACCESS(L) for transfers, or RST_CYCLES low for a bus reset.
  function automatic obs_t model(input vec_t v, input logic [DW-1:0] prev);
    obs_t e;
    bit   to;
    int   len;
    e.finished = 1'b1;
    e.retrig   = 1'b0;
    e.addr     = v.addr;
    e.wdata    = v.wdata;
    e.wr       = v.wr;
    if (v.preset) begin
      e.done   = 3 + int'(RSTC);
      e.psel_c = 0;
      e.pen_c  = 0;
      e.rst_c  = int'(RSTC);
      e.rdata  = prev;
      e.es     = 1'b0;
      e.et     = 1'b0;
    end else begin
      to       = (TOC != 0) && (v.waits >= int'(TOC));
      len      = to ? int'(TOC) : v.waits + 1;
      e.done   = 4 + len;
      e.psel_c = len + 1;
      e.pen_c  = len;
      e.rst_c  = 0;
      e.rdata  = v.wr ? prev : (to ? {DW{1'b1}} : v.rdv);
      e.es     = to ? 1'b0 : v.slverr;
      e.et     = to;
    end
    return e;
  endfunction

  // Runs one request from a negedge; acts as the APB slave and observes everything.
  task automatic do_txn(input vec_t v, output obs_t o);
    bit busy;
    int acc;
    o.finished = 1'b0; o.done = 0; o.psel_c = 0; o.pen_c = 0; o.rst_c = 0;
    o.addr = '0; o.wdata = '0; o.wr = 1'b0; o.retrig = 1'b0;
    paddr_in = v.addr; pwdata_in = v.wdata; pwrite_in = v.wr;
    assert_preset = v.preset; prdata = v.rdv; pslverr = v.slverr;
    pready = 1'b0;
    trans_start = 1'b1;
    busy = 1'b0;
    acc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge pclk);
      if (psel) o.psel_c = o.psel_c + 1;
      if (penable) o.pen_c = o.pen_c + 1;
      if (!presetn) o.rst_c = o.rst_c + 1;
      if (psel && penable) begin
        o.addr = paddr; o.wdata = pwdata; o.wr = pwrite;
      end
      if (!trans_done) begin
        busy = 1'b1;
      end else if (busy) begin
        o.done = c;
        o.finished = 1'b1;
        break;
      end
      pready = psel && penable && (acc == v.waits);
      if (psel && penable) acc++;
    end
    pready = 1'b0;
    o.rdata = rdata; o.es = err_slv; o.et = err_timeout;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (psel || !trans_done || !presetn) o.retrig = 1'b1;
    end
    trans_start = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic check_obs(input string tag, input int idx, input obs_t o, input obs_t e, input logic bus);
    chk({tag, "_finished"}, idx, 32'(o.finished), 32'(e.finished));
    chk({tag, "_done_edge"}, idx, 32'(o.done), 32'(e.done));
    chk({tag, "_psel_cyc"}, idx, 32'(o.psel_c), 32'(e.psel_c));
    chk({tag, "_penable_cyc"}, idx, 32'(o.pen_c), 32'(e.pen_c));
    chk({tag, "_presetn_low"}, idx, 32'(o.rst_c), 32'(e.rst_c));
    chk({tag, "_rdata"}, idx, 32'(o.rdata), 32'(e.rdata));
    chk({tag, "_err_slv"}, idx, 32'(o.es), 32'(e.es));
    chk({tag, "_err_timeout"}, idx, 32'(o.et), 32'(e.et));
    chk({tag, "_retrigger"}, idx, 32'(o.retrig), 32'(e.retrig));
    if (bus) begin
      chk({tag, "_paddr"}, idx, 32'(o.addr), 32'(e.addr));
      chk({tag, "_pwdata"}, idx, 32'(o.wdata), 32'(e.wdata));
      chk({tag, "_pwrite"}, idx, 32'(o.wr), 32'(e.wr));
    end
  endtask

  function automatic row_t mk(input logic pr, input logic wr, input int a, input int wd,
                              input int rv, input int w, input logic se, input int done,
                              input int rd, input logic es, input logic et);
    row_t r;
    r.v.preset = pr; r.v.wr = wr; r.v.addr = AW'(a); r.v.wdata = DW'(wd);
    r.v.rdv = DW'(rv); r.v.waits = w; r.v.slverr = se;
    r.done = done; r.rdata = DW'(rd); r.es = es; r.et = et;
    return r;
  endfunction

  row_t          tab[9];
  logic [DW-1:0] m_rdata;
  obs_t          o, e;
  vec_t          v;
  bit            hit;

  initial begin
    tab[0] = mk(0, 1, 5, 8'hA3, 8'h00, 0,     0, 5,  8'h00, 0, 0);
    tab[1] = mk(0, 0, 2, 8'h00, 8'h5C, 3,     0, 8,  8'h5C, 0, 0);
    tab[2] = mk(0, 0, 1, 8'h00, 8'h11, NEVER, 0, 20, 8'hFF, 0, 1);
    tab[3] = mk(0, 1, 3, 8'h3C, 8'h00, 1,     0, 6,  8'hFF, 0, 0);
    tab[4] = mk(1, 0, 6, 8'h00, 8'hEE, 0,     0, 7,  8'hFF, 0, 0);
    tab[5] = mk(0, 1, 7, 8'h81, 8'h00, 0,     1, 5,  8'hFF, 1, 0);
    tab[6] = mk(0, 0, 4, 8'h00, 8'h96, 15,    0, 20, 8'h96, 0, 0);
    tab[7] = mk(0, 0, 0, 8'h00, 8'h42, 16,    0, 20, 8'hFF, 0, 1);
    tab[8] = mk(0, 0, 6, 8'h00, 8'h24, 2,     1, 7,  8'h24, 1, 0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 0, 32'(psel), 32'(0));
    chk("rst_penable", 0, 32'(penable), 32'(0));
    chk("rst_presetn", 0, 32'(presetn), 32'(0));
    chk("rst_trans_done", 0, 32'(trans_done), 32'(1));
    chk("rst_rdata", 0, 32'(rdata), 32'(0));
    chk("rst_errs", 0, 32'({err_slv, err_timeout}), 32'(0));
    chk("rst_bus", 0, 32'({pwrite, paddr, pwdata}), 32'(0));
    rst = 1'b0;
    @(negedge pclk);
    chk("rst_presetn_release", 0, 32'(presetn), 32'(1));
    repeat (2) @(negedge pclk);

    // Reset asserted during ACCESS of a read
    paddr_in = 3'd3; pwrite_in = 1'b0; assert_preset = 1'b0; prdata = 8'h77; pready = 1'b0;
    trans_start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      if (psel && penable) begin hit = 1'b1; break; end
    end
    chk("midrst_reach_access", 0, 32'(hit), 32'(1));
    rst = 1'b1;
    @(negedge pclk);
    chk("midrst_psel", 0, 32'(psel), 32'(0));
    chk("midrst_penable", 0, 32'(penable), 32'(0));
    chk("midrst_trans_done", 0, 32'(trans_done), 32'(1));
    chk("midrst_rdata", 0, 32'(rdata), 32'(0));
    trans_start = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
    repeat (3) @(negedge pclk);
    m_rdata = '0;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      e = model(tab[i].v, m_rdata);
      e.done = tab[i].done; e.rdata = tab[i].rdata; e.es = tab[i].es; e.et = tab[i].et;
      do_txn(tab[i].v, o);
      check_obs("vec", i, o, e, !tab[i].v.preset);
      m_rdata = tab[i].rdata;
    end

    // Randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      v.preset = ($urandom_range(0, 7) == 0);
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = AW'($urandom_range(0, 7));
      v.wdata  = DW'($urandom_range(0, 255));
      v.rdv    = DW'($urandom_range(0, 255));
      v.waits  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 18));
      v.slverr = 1'($urandom_range(0, 1));
      e = model(v, m_rdata);
      do_txn(v, o);
      check_obs("rnd", i, o, e, !v.preset);
      m_rdata = e.rdata;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/itrx_apbm_apb_fsm.md
# itrx_apbm_apb_fsm

APB master sequencer that sits directly downstream of the SPI front-end FSM in the SPI-to-APB bridge. It runs on the divided APB clock and accepts the transfer request level, the address, write data and direction assembled by the SPI front-end. It then executes one APB3 transfer, or an APB bus-reset pulse, and returns a done level plus captured read data. It also provides a bounded-wait timeout so a hung slave cannot stall the SPI transaction.

## Interface
Parameters:
- ADDR_BITS_N, 3: APB address width.
- DATA_BITS_M, 8: APB data width.
- RST_CYCLES, 4: pclk cycles `presetn` is held low for a bus-reset request; legal range 1..255.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles waiting for `pready`; 0 disables the timeout; legal range 0..255.

Ports:
- pclk  in  1  APB clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- trans_start  in  1  request level from the SPI front-end. Synchronized internally by 2 flops. Held high until `trans_done` falls.
- assert_preset  in  1  qualifies the request as a bus reset. Sampled together with the request.
- paddr_in  in  ADDR_BITS_N  transfer address. Stable while a request is pending.
- pwdata_in  in  DATA_BITS_M  write data. Stable while a request is pending.
- pwrite_in  in  1  1 = write, 0 = read. Stable while a request is pending.
- pready  in  1  APB slave ready.
- prdata  in  DATA_BITS_M  APB slave read data.
- pslverr  in  1  APB slave error.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_BITS_N  APB address.
- pwdata  out  DATA_BITS_M  APB write data.
- presetn  out  1  APB bus reset, active low.
- trans_done  out  1  1 = idle or complete, 0 = busy.
- rdata  out  DATA_BITS_M  captured read data.
- err_slv  out  1  sticky slave-error flag, cleared at the next transfer start.
- err_timeout  out  1  sticky timeout flag, cleared at the next transfer start.

## Operation
- `req_s` is the 2-flop synchronized `trans_start`.
- All outputs are registered.
- States are IDLE, SETUP, ACCESS, BUSRST and DONE.
- IDLE:
  - `trans_done`=1.
  - On `req_s`=1: latch `paddr_in`, `pwdata_in` and `pwrite_in` into the `paddr`, `pwdata` and `pwrite` registers.
  - Clear `err_slv` and `err_timeout`, and drop `trans_done` to 0.
  - Go to BUSRST if `assert_preset`=1, else go to SETUP.
- SETUP: `psel`=1, `penable`=0. Load the timeout counter with TIMEOUT_CYCLES. Go to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - On `pready`=1:
    - Read: `rdata` ← `prdata`.
    - Any direction: `err_slv` ← `pslverr`.
    - Go to DONE.
  - Else, if TIMEOUT_CYCLES≠0: decrement the counter each cycle.
  - When the counter reaches 0 without `pready`:
    - `err_timeout` ← 1.
    - Read: `rdata` ← all-ones.
    - Go to DONE.
- BUSRST:
  - `presetn`=0 for exactly RST_CYCLES cycles; `psel`=`penable`=0.
  - On exit, `presetn` ← 1 and go to DONE.
  - `rdata` is unchanged.
- DONE: `psel`=`penable`=0, `trans_done`=1. Return to IDLE when `req_s`=0. A held request never retriggers.
- Any undefined state encoding returns to IDLE with all APB controls inactive.
- `pwrite`, `paddr` and `pwdata` keep their last values outside transfers.

## Timing
- Reset values:
  - state = IDLE, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0.
  - `presetn`=0 while `rst`=1, and 1 from the first cycle after `rst` deasserts.
  - `trans_done`=1, `rdata`=0, `err_slv`=0, `err_timeout`=0, both synchronizer flops 0.
- Request latency:
  - `trans_start` rising is seen by `req_s` after 2 pclk edges.
  - `psel` rises 1 edge later.
  - `trans_done` falls on the same edge that `psel` rises, or that `presetn` falls.
- Zero-wait transfer (`pready`=1 in the first ACCESS cycle):
  - `psel` is high for 2 cycles and `penable` for 1.
  - `trans_done` rises on the edge after the ACCESS cycle.
  - `rdata` is valid on that same edge.
- Wait states: each `pready`=0 cycle in ACCESS adds one cycle. With TIMEOUT_CYCLES=N, ACCESS lasts at most N cycles.
- `pready`=1 in the same cycle the counter hits 0: `pready` wins. Complete normally, no timeout.
- `assert_preset`=1 with `pwrite_in`=0: still a bus reset; no APB read is issued.
- `rst` mid-transfer: the next cycle goes to IDLE with reset values. `psel` and `penable` drop with no completion and no `rdata` update.
- `req_s` falling while in SETUP, ACCESS or BUSRST is ignored. The transfer completes, then DONE moves to IDLE immediately.

## Test plan
- Write, addr=5, data=0xA3, `pready` tied 1:
  - `psel` high 2 cycles, `penable` 1 cycle, `pwrite`=1, `paddr`=5, `pwdata`=0xA3.
  - `trans_done` rises 5 edges after `trans_start`.
- Read, addr=2, `prdata`=0x5C, `pready` low for 3 ACCESS cycles:
  - ACCESS lasts 4 cycles.
  - `rdata`=0x5C, `err_slv`=0.
- Read with `pready` never asserted, TIMEOUT_CYCLES=16:
  - ACCESS lasts exactly 16 cycles.
  - `err_timeout`=1, `rdata`=0xFF.
  - The next request clears `err_timeout`.
- Bus reset, `assert_preset`=1, RST_CYCLES=4:
  - `presetn` low exactly 4 cycles.
  - `psel` stays 0 and `rdata` is unchanged.
- Write with `pslverr`=1 on `pready`: `err_slv`=1, and the state still reaches DONE.
- `trans_start` held high through DONE: no second transfer. Then deassert, wait for IDLE, and reassert: exactly one new transfer.
- `rst` asserted during ACCESS: `psel`=`penable`=0 and `trans_done`=1 the next cycle, with `rdata` unchanged.
